// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned WORD_SHIFT = 2;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Parameterised synchronous circular FIFO with flush; flush overrides push/pop.
module ifu_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout  = store[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointer, occupancy and storage update; storage is cleared only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC, issue logic, range check and prefetch buffer.
// Optional performance counters enabled by defining IFU_PERF_CNT_EN.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        fetch_err
);

  localparam logic [XLEN-WORD_SHIFT-1:0] MEM_LIMIT = (XLEN-WORD_SHIFT)'(MEM_WORDS);

  logic [XLEN-1:0]       pc;
  logic                  dequeue;
  logic                  issue_req;
  logic                  in_range;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;

  assign inst_valid = ~fifo_empty;
  assign dequeue    = inst_valid & inst_ready;
  assign in_range   = (pc[XLEN-1:WORD_SHIFT] < MEM_LIMIT);
  // A full buffer still accepts a fetch when the head leaves in the same cycle.
  assign issue_req  = fetch_en & ~redirect_valid & ~fetch_err & ~reset & (~fifo_full | dequeue);
  assign mem_re     = issue_req & in_range;
  assign mem_addr   = pc >> WORD_SHIFT;
  assign push_entry = '{inst: mem_rdata, pc: pc};
  assign inst       = head_entry.inst;
  assign inst_pc    = head_entry.pc;

  // Occupancy and empty flag must agree.
  always_comb begin
    assert (fifo_empty == (fifo_count == '0));
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (mem_re),
    .pop   (dequeue),
    .din   (push_entry),
    .dout  (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // PC advance, redirect and sticky range-error tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      fetch_err <= 1'b0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc & ~XLEN'(3);
      fetch_err <= 1'b0;
    end else begin
      if (mem_re) begin
        pc <= pc + XLEN'(4);
      end
      if (issue_req && !in_range) begin
        fetch_err <= 1'b1;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Fetch and stall event counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (mem_re) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (fetch_en && !mem_re && !redirect_valid) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
